// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_pkg
// Purpose  : Register offsets, STATUS bit positions and FSM encoding for uart_tx_mmio.
// Revision : 1.0
// ============================================================================
package uart_tx_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIVLO  = 2'd2;
    localparam logic [1:0] REG_DIVHI  = 2'd3;

    localparam int STAT_FULL   = 0;
    localparam int STAT_EMPTY  = 1;
    localparam int STAT_BUSY   = 2;
    localparam int STAT_OVF    = 3;
    localparam int STAT_PARITY = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_e;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_fifo_sync.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_sync
// Purpose  : Single-clock FIFO with extra-MSB pointers; push into a full FIFO
//            succeeds only when a pop happens in the same cycle.
// Revision : 1.0
// ============================================================================
module uart_fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_aw = $clog2(DEPTH);

    logic [c_aw:0]      r_wr_ptr;
    logic [c_aw:0]      r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_do_push;
    logic               w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                       (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + {{c_aw{1'b0}}, 1'b1};
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{c_aw{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_aw-1:0]] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_mmio
// Purpose  : Memory-mapped 8N1 serial transmitter with byte FIFO and
//            programmable divisor. Define UART_TX_PARITY_EN for an even parity bit.
// Revision : 1.0
// ============================================================================
module uart_tx_mmio
    import uart_tx_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] addr,
    inout  wire  [7:0] data,
    input  logic       sel,
    input  logic       we,
    output logic       tx
);

`ifdef UART_TX_PARITY_EN
    localparam logic c_parity_build = 1'b1;
`else
    localparam logic c_parity_build = 1'b0;
`endif

    logic [15:0] r_div;
    logic        r_overflow;
    tx_state_e   r_state;
    logic [15:0] r_timer;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit_cnt;
`ifdef UART_TX_PARITY_EN
    logic        r_parity;
`endif

    logic [1:0]  w_reg;
    logic        w_wr;
    logic        w_rd;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic        w_bit_end;
    logic [7:0]  w_head;
    logic [7:0]  w_status;
    logic [7:0]  w_rdata;
    logic        w_unused;

    // Only the low two address bits decode; the slot aliases every 4 bytes.
    assign w_reg     = addr[1:0];
    assign w_unused  = ^addr[9:2];
    assign w_wr      = sel & we;
    assign w_rd      = sel & ~we;
    assign w_push    = w_wr && (w_reg == REG_DATA);
    assign w_bit_end = (r_timer == 16'd0);
    assign w_pop     = ~w_empty &&
                       ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

    uart_fifo_sync #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clock),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  (data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_status              = 8'h00;
        w_status[STAT_FULL]   = w_full;
        w_status[STAT_EMPTY]  = w_empty;
        w_status[STAT_BUSY]   = (r_state != S_IDLE);
        w_status[STAT_OVF]    = r_overflow;
        w_status[STAT_PARITY] = c_parity_build;
    end

    always_comb begin
        w_rdata = 8'h00;
        case (w_reg)
            REG_STATUS: w_rdata = w_status;
            REG_DIVLO:  w_rdata = r_div[7:0];
            REG_DIVHI:  w_rdata = r_div[15:8];
            default:    w_rdata = 8'h00;
        endcase
    end

    assign data = w_rd ? w_rdata : 8'bz;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_div      <= DIV_RESET;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr && (w_reg == REG_DIVLO)) r_div[7:0]  <= data;
            if (w_wr && (w_reg == REG_DIVHI)) r_div[15:8] <= data;
            // A pop in the same cycle frees a slot, so a push to a full FIFO is not lost then.
            if (w_push && w_full && !w_pop)
                r_overflow <= 1'b1;
            else if (w_wr && (w_reg == REG_STATUS))
                r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_timer   <= 16'd0;
            r_shift   <= 8'h00;
            r_bit_cnt <= 3'd0;
            tx        <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_head;
`ifdef UART_TX_PARITY_EN
                        r_parity <= even_parity(w_head);
`endif
                        r_timer <= r_div;
                        tx      <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_timer   <= r_div;
                        r_bit_cnt <= 3'd0;
                        tx        <= r_shift[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_timer <= r_div;
                        if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx      <= r_parity;
                            r_state <= S_PARITY;
`else
                            tx      <= 1'b1;
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_shift   <= {1'b0, r_shift[7:1]};
                            tx        <= r_shift[1];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_timer <= r_div;
                        tx      <= 1'b1;
                        r_state <= S_STOP;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        // Chain straight into the next frame when a byte is waiting.
                        if (w_pop) begin
                            r_shift <= w_head;
`ifdef UART_TX_PARITY_EN
                            r_parity <= even_parity(w_head);
`endif
                            r_timer <= r_div;
                            tx      <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            tx      <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                default: begin
                    tx      <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_mmio
// Purpose  : Self-checking bench: register tables, frame decoder and a
//            timing model of FIFO occupancy and frame start times.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_mmio;

    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int          c_nbits       = 11;
    localparam logic [7:0]  c_idle_status = 8'h12;
`else
    localparam int          c_nbits       = 10;
    localparam logic [7:0]  c_idle_status = 8'h02;
`endif

    logic       clock  = 1'b0;
    logic       reset  = 1'b1;
    logic       sel    = 1'b0;
    logic       we     = 1'b0;
    logic       drv_en = 1'b0;
    logic [9:0] addr   = 10'd0;
    logic [7:0] drv    = 8'h00;
    wire  [7:0] data_bus;
    logic       tx;

    assign data_bus = drv_en ? drv : 8'bz;

    uart_tx_mmio #(
        .FIFO_DEPTH (DEPTH),
        .DIV_RESET  (16'd15)
    ) dut (
        .clock (clock),
        .reset (reset),
        .addr  (addr),
        .data  (data_bus),
        .sel   (sel),
        .we    (we),
        .tx    (tx)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int mon_period = 16;

    logic [7:0] rx_byte[$];
    int         rx_start[$];
    bit         rx_ok[$];
    bit         rx_par[$];

    logic [7:0] seq_byte[16];
    int         seq_gap[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic bus_write(input logic [9:0] a, input logic [7:0] v, output int wcyc);
        @(negedge clock);
        addr = a; drv = v; drv_en = 1'b1; we = 1'b1; sel = 1'b1;
        @(posedge clock);
        #1;
        wcyc = cyc;
        sel = 1'b0; we = 1'b0; drv_en = 1'b0;
    endtask

    task automatic bus_read(input logic [9:0] a, output logic [7:0] v);
        @(negedge clock);
        addr = a; we = 1'b0; drv_en = 1'b0; sel = 1'b1;
        #1 v = data_bus;
        #1 sel = 1'b0;
    endtask

    task automatic set_div(input int d);
        int w;
        logic [15:0] dv;
        dv = 16'(d);
        bus_write(10'd2, dv[7:0], w);
        bus_write(10'd3, dv[15:8], w);
        mon_period = d + 1;
    endtask

    task automatic clear_rx();
        rx_byte.delete(); rx_start.delete(); rx_ok.delete(); rx_par.delete();
    endtask

    // Frame decoder: every level must hold for exactly one bit period.
    initial begin : monitor
        forever begin
            @(negedge clock);
            if (!reset && tx === 1'b0) begin : frame
                int st, p;
                bit ok;
                logic [7:0] b;
                logic pb;
                st = cyc; p = mon_period; ok = 1'b1; b = 8'h00; pb = 1'b0;
                for (int c = 1; c < p; c++) begin
                    @(negedge clock);
                    if (tx !== 1'b0) ok = 1'b0;
                end
                for (int i = 0; i < 8; i++) begin
                    for (int c = 0; c < p; c++) begin
                        @(negedge clock);
                        if (c == 0) b[i] = tx;
                        else if (tx !== b[i]) ok = 1'b0;
                    end
                end
`ifdef UART_TX_PARITY_EN
                for (int c = 0; c < p; c++) begin
                    @(negedge clock);
                    if (c == 0) pb = tx;
                    else if (tx !== pb) ok = 1'b0;
                end
                if (pb !== ^b) ok = 1'b0;
`endif
                for (int c = 0; c < p; c++) begin
                    @(negedge clock);
                    if (tx !== 1'b1) ok = 1'b0;
                end
                rx_byte.push_back(b); rx_start.push_back(st);
                rx_ok.push_back(ok);  rx_par.push_back(pb);
            end
        end
    end

    // Write seq_byte[0..n-1] with seq_gap idle cycles before each, then compare
    // decoded frames against a model: a byte starts at max(write+1, previous
    // start + frame length); a write is dropped if DEPTH bytes are still waiting
    // and none leaves on that same edge.
    task automatic run_seq(input int div, input int n, input string tag);
        int w[16], s[16];
        bit acc[16];
        int last_s, flen, cnt, nacc, idx, d, tmp;
        bit popnow, exp_ovf;
        logic [7:0] st;
        set_div(div);
        bus_write(10'd1, 8'h00, tmp);
        repeat (2) @(posedge clock);
        clear_rx();
        flen = c_nbits * (div + 1);
        for (int i = 0; i < n; i++) begin
            repeat (seq_gap[i]) @(posedge clock);
            bus_write(10'd0, seq_byte[i], w[i]);
        end
        last_s = -1000000; nacc = 0; exp_ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            cnt = 0; popnow = 1'b0;
            for (int j = 0; j < i; j++) begin
                if (acc[j] && s[j] >= w[i]) cnt++;
                if (acc[j] && s[j] == w[i]) popnow = 1'b1;
            end
            acc[i] = (cnt < DEPTH) || popnow;
            if (acc[i]) begin
                s[i] = (w[i] + 1 > last_s + flen) ? w[i] + 1 : last_s + flen;
                last_s = s[i];
                nacc++;
            end else begin
                exp_ovf = 1'b1;
            end
        end
        bus_read(10'd1, st);
        check({tag, " status_ovf"}, 32'(st[3]), 32'(exp_ovf));
        d = last_s + flen + 4 - cyc;
        if (d > 0) repeat (d) @(posedge clock);
        check({tag, " frames"}, 32'(rx_byte.size()), 32'(nacc));
        idx = 0;
        for (int i = 0; i < n; i++) begin
            if (acc[i] && idx < rx_byte.size()) begin
                check($sformatf("%s byte%0d", tag, i), 32'(rx_byte[idx]), 32'(seq_byte[i]));
                check($sformatf("%s start%0d", tag, i), 32'(rx_start[idx]), 32'(s[i]));
                check($sformatf("%s shape%0d", tag, i), 32'(rx_ok[idx]), 32'd1);
                idx++;
            end
        end
    endtask

    typedef struct {
        logic [9:0] addr;
        logic [7:0] exp;
        string      name;
    } rd_vec_t;

    typedef struct {
        logic [9:0] waddr;
        logic [7:0] wdata;
        logic [9:0] raddr;
        logic [7:0] exp;
        string      name;
    } wr_vec_t;

    rd_vec_t rd_tab[5];
    wr_vec_t wr_tab[5];

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] v;
        int w, zeros;

        rd_tab[0] = '{10'h001, c_idle_status, "rst_status"};
        rd_tab[1] = '{10'h002, 8'h0F,         "rst_divlo"};
        rd_tab[2] = '{10'h003, 8'h00,         "rst_divhi"};
        rd_tab[3] = '{10'h000, 8'h00,         "data_read"};
        rd_tab[4] = '{10'h3FD, c_idle_status, "status_alias"};

        wr_tab[0] = '{10'h002, 8'h5A, 10'h002, 8'h5A,         "divlo_rw"};
        wr_tab[1] = '{10'h003, 8'hC3, 10'h107, 8'hC3,         "divhi_alias_rd"};
        wr_tab[2] = '{10'h20A, 8'h03, 10'h002, 8'h03,         "divlo_alias_wr"};
        wr_tab[3] = '{10'h003, 8'h00, 10'h003, 8'h00,         "divhi_clear"};
        wr_tab[4] = '{10'h001, 8'hFF, 10'h001, c_idle_status, "status_wr"};

        repeat (2) @(posedge clock);
        #1 check("rst_tx", 32'(tx), 32'd1);
        bus_read(10'd1, v);
        check("rst_status_in_reset", 32'(v), 32'(c_idle_status));
        @(negedge clock) reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            bus_read(rd_tab[i].addr, v);
            check(rd_tab[i].name, 32'(v), 32'(rd_tab[i].exp));
        end
        for (int i = 0; i < 5; i++) begin
            bus_write(wr_tab[i].waddr, wr_tab[i].wdata, w);
            bus_read(wr_tab[i].raddr, v);
            check(wr_tab[i].name, 32'(v), 32'(wr_tab[i].exp));
        end

        seq_byte[0] = 8'hA5; seq_gap[0] = 0;
        run_seq(3, 1, "a5_div3");

        for (int i = 0; i < 6; i++) begin
            seq_byte[i] = 8'(8'h10 + i); seq_gap[i] = 0;
        end
        run_seq(0, 5, "burst5_div0");
        run_seq(255, 6, "burst6_div255");
        bus_write(10'd1, 8'h00, w);
        bus_read(10'd1, v);
        check("ovf_cleared", 32'(v), 32'(c_idle_status));

        seq_byte[0] = 8'h01; seq_byte[1] = 8'h80; seq_gap[0] = 0; seq_gap[1] = 0;
        run_seq(2, 2, "b2b");
        if (rx_start.size() >= 2)
            check("b2b_no_gap", 32'(rx_start[1] - rx_start[0]), 32'(3 * c_nbits));

        seq_byte[0] = 8'h07; seq_byte[1] = 8'h03;
        run_seq(1, 2, "par_div1");
        if (rx_start.size() >= 2) begin
            check("frame_len_div1", 32'(rx_start[1] - rx_start[0]), 32'(2 * c_nbits));
`ifdef UART_TX_PARITY_EN
            check("parity_07", 32'(rx_par[0]), 32'd1);
            check("parity_03", 32'(rx_par[1]), 32'd0);
`endif
        end

        // Reset in the middle of the data bits of 8'h3C.
        set_div(3);
        bus_write(10'd0, 8'h3C, w);
        repeat (12) @(posedge clock);
        bus_read(10'd1, v);
        check("midframe_busy", 32'(v), 32'(c_idle_status | 8'h04));
        @(negedge clock) reset = 1'b1;
        @(posedge clock);
        #1 check("midreset_tx", 32'(tx), 32'd1);
        bus_read(10'd1, v);
        check("midreset_status", 32'(v), 32'(c_idle_status));
        @(negedge clock) reset = 1'b0;
        zeros = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clock);
            if (tx !== 1'b1) zeros++;
        end
        check("midreset_no_frame", 32'(zeros), 32'd0);
        bus_read(10'd2, v);
        check("midreset_divlo", 32'(v), 32'h0F);
        clear_rx();

        for (int r = 0; r < 3; r++) begin
            int dv;
            dv = int'($urandom_range(0, 2));
            for (int i = 0; i < 8; i++) begin
                seq_byte[i] = 8'($urandom);
                seq_gap[i]  = int'($urandom_range(0, 3 * c_nbits * (dv + 1)));
            end
            run_seq(dv, 8, $sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
